// File: rtl/clock_ctrl.sv
// clock_ctrl: run/halt/step sequencer producing a divided core clock level and
// a one-cycle core tick enable, with a warm-up delay before ticking starts.
module clock_ctrl #(
   parameter int DIV_W     = 8,
   parameter int STEP_W    = 16,
   parameter int START_DLY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [STEP_W-1:0] cmd_arg,
   output logic              core_en,
   output logic              core_clk,
   output logic              running,
   output logic              step_done
);
   localparam int WW = START_DLY > 1 ? $clog2(START_DLY) : 1;
   localparam logic [1:0] OP_HALT = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_DIV = 2'b11;

   typedef enum logic [1:0] {IDLE, WARM, RUN, STEP} state_t;

   state_t            state, state_n;
   logic [DIV_W-1:0]  div, div_n, cnt, cnt_n, div_next, div_next_n, arg_div;
   logic [STEP_W-1:0] steps_left, steps_left_n;
   logic [WW-1:0]     warm_cnt, warm_cnt_n;
   logic [DIV_W:0]    half;
   logic              mode, mode_n, halt_pend, halt_pend_n, div_pend, div_pend_n;
   logic              step_done_n, acc, last, leave;

   assign running   = state == RUN || state == STEP;
   assign core_en   = running && cnt == div - DIV_W'(1);
   assign half      = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
   assign core_clk  = running && {1'b0, cnt} < half;
   assign cmd_ready = state != WARM && !halt_pend;
   assign acc       = cmd_valid && cmd_ready;
   assign arg_div   = cmd_arg[DIV_W-1:0] == '0 ? DIV_W'(1) : cmd_arg[DIV_W-1:0];
   assign last      = state == STEP && core_en && steps_left == STEP_W'(1);
   assign leave     = core_en && (halt_pend || last);

   always_comb begin
      state_n      = state;
      div_n        = div;
      cnt_n        = cnt;
      div_next_n   = div_next;
      div_pend_n   = div_pend;
      halt_pend_n  = halt_pend;
      steps_left_n = steps_left;
      warm_cnt_n   = warm_cnt;
      mode_n       = mode;
      step_done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (acc && (cmd_op == OP_RUN || (cmd_op == OP_STEP && cmd_arg != '0))) begin
               mode_n       = cmd_op[1];
               steps_left_n = cmd_arg;
               cnt_n        = '0;
               warm_cnt_n   = '0;
               state_n      = START_DLY == 0 ? (cmd_op[1] ? STEP : RUN) : WARM;
            end else if (acc && cmd_op == OP_STEP) begin
               step_done_n = 1'b1;
            end else if (acc && cmd_op == OP_DIV) begin
               div_n = arg_div;
               cnt_n = '0;
            end
         end
         WARM: begin
            if (warm_cnt == WW'(START_DLY - 1)) begin
               state_n = mode ? STEP : RUN;
               cnt_n   = '0;
            end else begin
               warm_cnt_n = warm_cnt + WW'(1);
            end
         end
         default: begin
            if (core_en) begin
               cnt_n = '0;
               if (div_pend) begin
                  div_n      = div_next;
                  div_pend_n = 1'b0;
               end
               if (state == STEP) steps_left_n = steps_left - STEP_W'(1);
               if (leave) begin
                  state_n     = IDLE;
                  halt_pend_n = 1'b0;
                  step_done_n = last;
               end
            end else begin
               cnt_n = cnt + DIV_W'(1);
            end
            // a divide arriving on the cycle we drop to IDLE would never see another boundary
            if (acc && cmd_op == OP_DIV && leave) begin
               div_n = arg_div;
            end else if (acc && cmd_op == OP_DIV) begin
               div_pend_n = 1'b1;
               div_next_n = arg_div;
            end
            if (acc && cmd_op == OP_HALT && !leave) halt_pend_n = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div        <= DIV_W'(1);
         cnt        <= '0;
         div_next   <= '0;
         div_pend   <= 1'b0;
         halt_pend  <= 1'b0;
         steps_left <= '0;
         warm_cnt   <= '0;
         mode       <= 1'b0;
         step_done  <= 1'b0;
      end else begin
         state      <= state_n;
         div        <= div_n;
         cnt        <= cnt_n;
         div_next   <= div_next_n;
         div_pend   <= div_pend_n;
         halt_pend  <= halt_pend_n;
         steps_left <= steps_left_n;
         warm_cnt   <= warm_cnt_n;
         mode       <= mode_n;
         step_done  <= step_done_n;
      end
   end
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed checks of clock_ctrl run/step/halt/divide sequencing.
module tb_clock_ctrl;
   logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
   logic        cmd_ready, core_en, core_clk, running, step_done;
   logic [1:0]  cmd_op = 2'b00;
   logic [15:0] cmd_arg = '0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   clock_ctrl #(.DIV_W(8), .STEP_W(16), .START_DLY(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .core_en(core_en), .core_clk(core_clk),
      .running(running), .step_done(step_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic v, input logic [1:0] op, input logic [15:0] a);
      cmd_valid = v;
      cmd_op    = op;
      cmd_arg   = a;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cmd(1'b0, 2'b00, 16'd0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // vector order: {cmd_ready, running, core_clk, core_en, step_done}
   task automatic obs(input string tag, input int k, input logic [4:0] exp);
      check($sformatf("%s@%0d", tag, k),
            {27'd0, cmd_ready, running, core_clk, core_en, step_done}, {27'd0, exp});
   endtask

   initial begin
      logic rdy, r, c, e, d;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         obs("idle", k, 5'b10000);
         tick();
      end

      // div=3 then RUN at cycle 0
      do_reset();
      cmd(1'b1, 2'b11, 16'd3);
      tick();
      for (int k = 0; k <= 14; k++) begin
         cmd(k == 0, 2'b01, 16'd0);
         rdy = !(k >= 1 && k <= 4);
         r   = k >= 5;
         c   = r && (k - 5) % 3 < 2;
         e   = r && (k - 5) % 3 == 2;
         obs("run3", k, {rdy, r, c, e, 1'b0});
         tick();
      end

      // SET_DIV 2 at 0, STEP 3 at 2
      do_reset();
      for (int k = 0; k <= 16; k++) begin
         if (k == 0) cmd(1'b1, 2'b11, 16'd2);
         else if (k == 2) cmd(1'b1, 2'b10, 16'd3);
         else cmd(1'b0, 2'b00, 16'd0);
         rdy = !(k >= 3 && k <= 6);
         r   = k >= 7 && k <= 12;
         c   = r && (k - 7) % 2 == 0;
         e   = r && (k - 7) % 2 == 1;
         d   = k == 13;
         obs("step3", k, {rdy, r, c, e, d});
         tick();
      end

      // div=4 RUN at 1, HALT mid-period at 11
      do_reset();
      for (int k = 0; k <= 20; k++) begin
         if (k == 0) cmd(1'b1, 2'b11, 16'd4);
         else if (k == 1) cmd(1'b1, 2'b01, 16'd0);
         else if (k == 11) cmd(1'b1, 2'b00, 16'd0);
         else cmd(1'b0, 2'b00, 16'd0);
         rdy = !(k >= 2 && k <= 5) && !(k >= 12 && k <= 13);
         r   = k >= 6 && k <= 13;
         c   = r && (k - 6) % 4 < 2;
         e   = r && (k - 6) % 4 == 3;
         obs("halt", k, {rdy, r, c, e, 1'b0});
         tick();
      end

      // STEP 0: step_done only
      do_reset();
      for (int k = 0; k <= 4; k++) begin
         cmd(k == 0, 2'b10, 16'd0);
         d = k == 1;
         obs("step0", k, {1'b1, 1'b0, 1'b0, 1'b0, d});
         tick();
      end

      // SET_DIV 0 acts as div=1
      do_reset();
      for (int k = 0; k <= 10; k++) begin
         if (k == 0) cmd(1'b1, 2'b11, 16'd0);
         else if (k == 1) cmd(1'b1, 2'b01, 16'd0);
         else cmd(1'b0, 2'b00, 16'd0);
         rdy = !(k >= 2 && k <= 5);
         r   = k >= 6;
         obs("div0", k, {rdy, r, r, r, 1'b0});
         tick();
      end

      // reset during STEP 5 at div=1
      do_reset();
      for (int k = 0; k <= 14; k++) begin
         cmd(k == 0, 2'b10, 16'd5);
         rst = k == 7;
         rdy = k >= 8 || !(k >= 1 && k <= 4);
         r   = k >= 5 && k <= 7;
         obs("rststep", k, {rdy, r, r, r, 1'b0});
         tick();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
